wb_pipe_master: RTL
===================

Name: wb_pipe_master

Overview:
- Single-outstanding Wishbone B4 pipelined-mode initiator (master).
- Converts a simple valid/ready request from core-side logic (CPU load/store unit, test sequencer) into one Wishbone cycle.
- Honours o_wb_stall/i_wb_stall and ack from the peripheral slaves on the intercon.
- Returns read data or an error flag through a one-cycle response pulse.
- Bounds every cycle with an ack timeout so a dead slave cannot hang the core.

Parameters:
- ADDR_W, 32, Wishbone/request address width.
- DATA_W, 32, Wishbone/request data width.
- TIMEOUT, 16, max cycles from first strobe to ack before abort; legal range 2..255.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request.
- i_req_we  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_W  request address.
- i_req_wdata  in  DATA_W  write data.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- o_rsp_err  out  1  timeout abort, qualified by o_rsp_valid.
- o_wb_addr  out  ADDR_W  Wishbone address.
- o_wb_data  out  DATA_W  Wishbone write data.
- o_wb_cyc  out  1  cycle.
- o_wb_stb  out  1  strobe.
- o_wb_we  out  1  write enable.
- i_wb_data  in  DATA_W  slave read data.
- i_wb_ack  in  1  slave acknowledge.
- i_wb_stall  in  1  slave stall.

Behaviour:
- Reset (async, i_rst=1):
  - state IDLE; o_wb_cyc=o_wb_stb=o_wb_we=0.
  - o_wb_addr=o_wb_data=0; o_rsp_valid=o_rsp_err=0; o_rsp_rdata=0; timeout counter=0.
  - Reset mid-cycle drops cyc/stb immediately (combinationally via async clear); the in-flight request is lost and no response is issued.
- All outputs are registered. o_req_ready=1 only in IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On i_req_valid & o_req_ready (edge N): latch addr/wdata/we onto the o_wb_* registers; cyc=stb=1 from cycle N+1; counter=0; go to REQ.
- REQ (cyc=1, stb=1):
  - i_wb_stall=1: hold stb, addr, data and we stable; counter++.
  - i_wb_stall=0: request is accepted this edge; stb=0 next cycle.
    - If i_wb_ack also =1 the same edge: go to RESP.
    - Otherwise: go to WAIT.
  - i_wb_ack while i_wb_stall=1 is ignored (protocol violation, no effect).
- WAIT (cyc=1, stb=0):
  - i_wb_ack=1: capture i_wb_data (reads only), cyc=0, go to RESP.
  - Otherwise: counter++.
- Timeout:
  - Counter counts every cycle in REQ and WAIT from the first stb cycle.
  - Reaching TIMEOUT-1 without ack (ack on that same edge wins): cyc=stb=0; go to RESP with err=1, rdata=0.
- RESP:
  - o_rsp_valid=1 for exactly one cycle; cyc=0; rdata is the captured i_wb_data for an acked read, else 0.
  - Next state IDLE.
  - o_rsp_rdata/o_rsp_err hold their value until the next response.
- Latency: request accept -> o_rsp_valid minimum 3 cycles (N+1 stb, ack on that edge, N+2 RESP pulse). Back-to-back: next request can be accepted in the cycle after RESP.
- Acks arriving in IDLE/RESP (stray) are ignored.
- Widths pass through unchanged. Counter is 8-bit and saturates; no arithmetic on data.

Test Plan:
1. Read, zero-wait slave (stall=0, ack on first stb edge, i_wb_data=0xDEADBEEF) -> stb high exactly 1 cycle; o_rsp_valid 1 cycle later; o_rsp_rdata=0xDEADBEEF; err=0.
2. Write addr 0x10, data 0x12345678; slave stalls 2 cycles then acks 1 cycle after acceptance -> stb high 3 cycles with addr/data/we stable; cyc drops after ack; rsp_valid=1, rdata=0, err=0.
3. Read with no ack ever, TIMEOUT=16 -> cyc falls after 16 cycles of cyc; rsp_valid pulse with err=1, rdata=0; o_req_ready=1 the next cycle.
4. Assert i_rst for 1 cycle while in WAIT -> cyc/stb=0 immediately; no rsp_valid; a subsequent read to 0x4 completes normally.
5. Two back-to-back requests (write 0xA5A5A5A5, then read returning 0xFFFFFFFF) -> o_req_ready low between; exactly two rsp pulses in order; second rdata=0xFFFFFFFF.
6. Stray i_wb_ack pulses in IDLE, plus ack with stall=1 in REQ -> no state change, no response, stb held until stall=0.

Source files
------------

// File: rtl/wb_pipe_master_if.sv
// Bundle of the core-side request/response handshake and the Wishbone B4 pipelined bus.
// Directions are named from the master's point of view.
interface wb_pipe_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [ADDR_W-1:0] i_req_addr;
    logic [DATA_W-1:0] i_req_wdata;

    logic              o_rsp_valid;
    logic [DATA_W-1:0] o_rsp_rdata;
    logic              o_rsp_err;

    logic [ADDR_W-1:0] o_wb_addr;
    logic [DATA_W-1:0] o_wb_data;
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic              o_wb_we;
    logic [DATA_W-1:0] i_wb_data;
    logic              i_wb_ack;
    logic              i_wb_stall;

    modport master (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata,
        input  i_wb_data, i_wb_ack, i_wb_stall,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_wb_addr, o_wb_data, o_wb_cyc, o_wb_stb, o_wb_we
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata,
        output i_wb_data, i_wb_ack, i_wb_stall,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_wb_addr, o_wb_data, o_wb_cyc, o_wb_stb, o_wb_we
    );
endinterface

// File: rtl/wb_pipe_master.sv
// Single-outstanding Wishbone B4 pipelined master: one request in, one bus cycle,
// one response pulse out, with an ack timeout so a dead slave cannot hang the core.
module wb_pipe_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    wb_pipe_master_if.master      bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        tmo_cnt;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic              ack_taken;
    logic              tmo_hit;

    // An ack only counts in WAIT, or in REQ on the edge the strobe is accepted.
    assign ack_taken = bus.i_wb_ack && ((state == WAIT) || ((state == REQ) && !bus.i_wb_stall));
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            tmo_cnt   <= 8'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_we     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        wb_addr   <= bus.i_req_addr;
                        wb_data   <= bus.i_req_wdata;
                        wb_we     <= bus.i_req_we;
                        wb_cyc    <= 1'b1;
                        wb_stb    <= 1'b1;
                        tmo_cnt   <= 8'd0;
                        req_ready <= 1'b0;
                        state     <= REQ;
                    end
                end
                REQ, WAIT: begin
                    // An ack on the final counted edge beats the timeout.
                    if (ack_taken) begin
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= wb_we ? '0 : bus.i_wb_data;
                        state     <= RESP;
                    end else if (tmo_hit) begin
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        tmo_cnt <= (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
                        if ((state == REQ) && !bus.i_wb_stall) begin
                            wb_stb <= 1'b0;
                            state  <= WAIT;
                        end
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ready = req_ready;
    assign bus.o_rsp_valid = rsp_valid;
    assign bus.o_rsp_rdata = rsp_rdata;
    assign bus.o_rsp_err   = rsp_err;
    assign bus.o_wb_addr   = wb_addr;
    assign bus.o_wb_data   = wb_data;
    assign bus.o_wb_cyc    = wb_cyc;
    assign bus.o_wb_stb    = wb_stb;
    assign bus.o_wb_we     = wb_we;

endmodule
